// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin arbiter multiplexing NUM_REQ command requesters onto one i2c_master.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rd,
  input  logic [7*NUM_REQ-1:0] req_chip_addr,
  input  logic [8*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 ack_err,
  output logic [7:0]           rd_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [6:0]           m_chip_addr,
  output logic [7:0]           m_reg_addr,
  output logic [7:0]           m_data_in,
  output logic                 m_write_en,
  output logic                 m_read_en,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic [2:0]           m_status,
  input  logic [7:0]           m_data_out
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_ACK} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last_owner, owner, win;
  logic rd_op, timeout;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  logic in_wait;
  assign in_wait = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
  assign timeout = in_wait && (wd == WW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk)
    if (reset || !in_wait) wd <= '0;
    else wd <= wd + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  // Descending scan so the requester closest after last_owner is assigned last and wins.
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(last_owner) + 1 + k) % NUM_REQ]) win = IW'((int'(last_owner) + 1 + k) % NUM_REQ);
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      state_nx = |req ? S_ISSUE : S_IDLE;
      S_ISSUE:     state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: state_nx = (timeout || m_done) ? S_ACK : m_busy ? S_WAIT_DONE : S_WAIT_BUSY;
      S_WAIT_DONE: state_nx = (timeout || m_done || !m_busy) ? S_ACK : S_WAIT_DONE;
      S_ACK:       state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end
  assign m_write_en = (state == S_ISSUE) && !rd_op;
  assign m_read_en  = (state == S_ISSUE) && rd_op;
  assign ack        = (state == S_ACK) ? grant : '0;
  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (reset) begin
      grant       <= '0;
      owner       <= '0;
      last_owner  <= IW'(NUM_REQ - 1);
      rd_op       <= 1'b0;
      m_chip_addr <= '0;
      m_reg_addr  <= '0;
      m_data_in   <= '0;
      rd_data     <= '0;
      ack_err     <= 1'b0;
    end else begin
      if (state == S_IDLE && |req) begin
        grant       <= NUM_REQ'(1) << win;
        owner       <= win;
        rd_op       <= req_rd[win];
        m_chip_addr <= req_chip_addr[win*7 +: 7];
        m_reg_addr  <= req_reg_addr[win*8 +: 8];
        m_data_in   <= req_data[win*8 +: 8];
      end
      if (state != S_ACK && state_nx == S_ACK) begin
        rd_data <= timeout ? 8'h00 : m_data_out;
        ack_err <= timeout || (m_status != 3'd0);
      end
      if (state == S_ACK) begin
        grant      <= '0;
        last_owner <= owner;
      end
    end
endmodule
